id_issue_sb: RTL and testbench

- Parametrised successor to the decode-stage hazard logic: a register scoreboard plus an ID→EX pipeline register with a valid/ready handshake.
- Replaces the fixed single-cycle load-use compare with per-register busy tracking for long-latency producers. It supports any number of outstanding loads, up to a bound.
- Sits between the IF/ID register and EX. It consumes a fetched instruction and the writeback notifications, and issues decoded register indices to EX.

---
 rtl/id_issue_sb_pkg.sv | 27 ++
 rtl/id_issue_sb_scoreboard.sv | 48 ++++
 rtl/id_issue_sb.sv | 128 ++++++++++++
 tb/tb_id_issue_sb.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_sb_pkg.sv
// Shared decode constants for the ID-stage issue scoreboard (id_issue_sb).
// Opcodes are the RV instr[6:2] field; calc_rw sizes register index ports.
package id_issue_sb_pkg;

    typedef enum logic [4:0] {
        OPC_LOAD      = 5'b00000,
        OPC_OP_IMM    = 5'b00100,
        OPC_AUIPC     = 5'b00101,
        OPC_OP_IMM_32 = 5'b00110,
        OPC_STORE     = 5'b01000,
        OPC_OP_REG    = 5'b01100,
        OPC_LUI       = 5'b01101,
        OPC_OP_REG_32 = 5'b01110,
        OPC_BRANCH    = 5'b11000,
        OPC_JALR      = 5'b11001,
        OPC_JAL       = 5'b11011
    } opcode_e;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;
    localparam logic [1:0] INSTR_32BIT = 2'b11;
    localparam int         OUTST_W     = 4;

    function automatic int calc_rw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/id_issue_sb_scoreboard.sv
// Register busy vector and outstanding long-op counter for id_issue_sb.
// A same-cycle set and clear of one register leaves it busy (new producer wins).
module id_scoreboard
    import id_issue_sb_pkg::*;
#(
    parameter int NREG = 32,
    localparam int RW  = calc_rw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [RW-1:0]       set_rd,
    input  logic                clr_en,
    input  logic [RW-1:0]       clr_rd,
    output logic [NREG-1:0]     busy,
    output logic [NREG-1:0]     busy_eff,
    output logic                clr_hit,
    output logic [OUTST_W-1:0]  outst
);

    logic                set_hit;
    logic [NREG-1:0]     set_mask;
    logic [NREG-1:0]     clr_mask;

    // Only a clear of a register that is actually busy counts; x0 never tracks.
    always_comb begin
        clr_hit  = clr_en && (clr_rd != '0) && busy[clr_rd];
        set_hit  = set_en && (set_rd != '0);
        clr_mask = clr_hit ? ({{(NREG-1){1'b0}}, 1'b1} << clr_rd) : '0;
        set_mask = set_hit ? ({{(NREG-1){1'b0}}, 1'b1} << set_rd) : '0;
        busy_eff = busy & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            outst <= '0;
        end else begin
            busy <= busy_eff | set_mask;
            if (set_hit && !clr_hit) begin
                outst <= outst + OUTST_W'(1);
            end else if (!set_hit && clr_hit) begin
                outst <= outst - OUTST_W'(1);
            end
        end
    end

endmodule

// File: rtl/id_issue_sb.sv
// Decode-stage hazard check and ID->EX register with valid/ready handshake.
// Optional macro MDU_SCOREBOARD_EN makes mul/div ops scoreboard-tracked as well.
module id_issue_sb
    import id_issue_sb_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NREG      = 32,
    parameter int MAX_OUTST = 4,
    localparam int RW       = calc_rw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [31:0]         instr_i,
    input  logic                flush_i,
    input  logic                wb_clr_i,
    input  logic [RW-1:0]       wb_rdid_i,
    output logic                ex_valid_o,
    input  logic                ex_ready_i,
    output logic [XLEN-1:0]     ex_pc_o,
    output logic [31:0]         ex_instr_o,
    output logic [RW-1:0]       ex_rs1_o,
    output logic [RW-1:0]       ex_rs2_o,
    output logic [RW-1:0]       ex_rd_o,
    output logic                ex_long_o,
    output logic [NREG-1:0]     busy_o,
    output logic [OUTST_W-1:0]  outst_o
);

    opcode_e          opcode;
    logic             use_rs1, use_rs2, use_rd;
    logic [RW-1:0]    rs1, rs2, rd;
    logic             long_op;
    logic             hazard, out_free, fire;
    logic [NREG-1:0]  busy_eff;
    logic             clr_hit;

    assign opcode = opcode_e'(instr_i[6:2]);

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OPC_OP_REG, OPC_OP_REG_32: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_JAL, OPC_LUI, OPC_AUIPC: use_rd = 1'b1;
            default: ;
        endcase
    end

    assign rs1 = use_rs1 ? RW'(instr_i[19:15]) : '0;
    assign rs2 = use_rs2 ? RW'(instr_i[24:20]) : '0;
    assign rd  = use_rd  ? RW'(instr_i[11:7])  : '0;

`ifdef MDU_SCOREBOARD_EN
    logic mdu_op;
    assign mdu_op  = ((opcode == OPC_OP_REG) || (opcode == OPC_OP_REG_32)) &&
                     (instr_i[31:25] == FUNCT7_MEXT);
    assign long_op = (((opcode == OPC_LOAD) && (instr_i[1:0] == INSTR_32BIT)) || mdu_op) &&
                     (rd != '0);
`else
    assign long_op = (opcode == OPC_LOAD) && (instr_i[1:0] == INSTR_32BIT) && (rd != '0);
`endif

    id_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fire && long_op),
        .set_rd   (rd),
        .clr_en   (wb_clr_i),
        .clr_rd   (wb_rdid_i),
        .busy     (busy_o),
        .busy_eff (busy_eff),
        .clr_hit  (clr_hit),
        .outst    (outst_o)
    );

    // The full-count stall is lifted only by a writeback that really retires
    // an op, so the counter can never exceed MAX_OUTST.
    always_comb begin
        hazard   = (use_rs1 && busy_eff[rs1]) ||
                   (use_rs2 && busy_eff[rs2]) ||
                   (use_rd  && busy_eff[rd])  ||
                   (long_op && (outst_o == OUTST_W'(MAX_OUTST)) && !clr_hit);
        out_free   = !ex_valid_o || ex_ready_i;
        in_ready_o = out_free && !hazard && !flush_i;
        fire       = in_valid_i && in_ready_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_o <= 1'b0;
            ex_pc_o    <= '0;
            ex_instr_o <= '0;
            ex_rs1_o   <= '0;
            ex_rs2_o   <= '0;
            ex_rd_o    <= '0;
            ex_long_o  <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (fire) begin
            ex_valid_o <= 1'b1;
            ex_pc_o    <= pc_i;
            ex_instr_o <= instr_i;
            ex_rs1_o   <= rs1;
            ex_rs2_o   <= rs2;
            ex_rd_o    <= rd;
            ex_long_o  <= long_op;
        end else if (out_free) begin
            ex_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_issue_sb.sv
// Self-checking bench for id_issue_sb: vector table, directed corner sequences
// and randomized traffic compared against a behavioural scoreboard model.
module tb_id_issue_sb;

    localparam int XLEN      = 64;
    localparam int NREG      = 32;
    localparam int MAX_OUTST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [XLEN-1:0]   pc_i;
    logic [31:0]       instr_i;
    logic              flush_i;
    logic              wb_clr_i;
    logic [4:0]        wb_rdid_i;
    logic              ex_valid_o;
    logic              ex_ready_i;
    logic [XLEN-1:0]   ex_pc_o;
    logic [31:0]       ex_instr_o;
    logic [4:0]        ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic              ex_long_o;
    logic [NREG-1:0]   busy_o;
    logic [3:0]        outst_o;

    id_issue_sb #(.XLEN(XLEN), .NREG(NREG), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .flush_i(flush_i), .wb_clr_i(wb_clr_i),
        .wb_rdid_i(wb_rdid_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_pc_o(ex_pc_o), .ex_instr_o(ex_instr_o), .ex_rs1_o(ex_rs1_o),
        .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_long_o(ex_long_o),
        .busy_o(busy_o), .outst_o(outst_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural view of the scoreboard and the EX register
    bit           m_busy[NREG];
    int           m_outst;
    bit           m_valid;
    logic [63:0]  m_pc;
    logic [31:0]  m_instr;
    int           m_rs1, m_rs2, m_rd;
    bit           m_long;
    bit           last_ready;
    logic [63:0]  pc_ctr = 64'h1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int rd, input logic [6:0] opc);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), opc};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] opc);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), opc};
    endfunction
    function automatic logic [31:0] ld(input int rd, input int rs1);
        return enc_i(0, rs1, 3, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
        return enc_r(0, rs2, rs1, rd, 7'b0110011);
    endfunction
    function automatic logic [31:0] mul(input int rd, input int rs1, input int rs2);
        return enc_r(1, rs2, rs1, rd, 7'b0110011);
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] sd(input int rs2, input int rs1);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b011, 5'b0, 7'b0100011};
    endfunction
    function automatic logic [31:0] beq(input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b0, 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input int rd);
        return {20'h00100, 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] lui(input int rd);
        return {20'h12345, 5'(rd), 7'b0110111};
    endfunction

    // Which register fields an instruction reads/writes, and whether it is tracked
    function automatic void model_decode(input logic [31:0] ins, output bit u1, output bit u2,
                                         output bit wr, output bit lng,
                                         output int r1, output int r2, output int rd);
        logic [4:0] opc;
        opc = ins[6:2];
        {u1, u2, wr} = 3'b000;
        case (opc)
            5'b01100, 5'b01110:                   {u1, u2, wr} = 3'b111;
            5'b00100, 5'b00110, 5'b00000, 5'b11001: {u1, u2, wr} = 3'b101;
            5'b01000, 5'b11000:                   {u1, u2, wr} = 3'b110;
            5'b11011, 5'b01101, 5'b00101:         {u1, u2, wr} = 3'b001;
            default:                              {u1, u2, wr} = 3'b000;
        endcase
        r1 = u1 ? int'(ins[19:15]) : 0;
        r2 = u2 ? int'(ins[24:20]) : 0;
        rd = wr ? int'(ins[11:7])  : 0;
        lng = (opc == 5'b00000) && (ins[1:0] == 2'b11) && (rd != 0);
`ifdef MDU_SCOREBOARD_EN
        if ((opc == 5'b01100 || opc == 5'b01110) && ins[31:25] == 7'b0000001 && rd != 0)
            lng = 1'b1;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_outst = 0; m_valid = 0; m_pc = '0; m_instr = '0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_long = 0;
    endtask

    task automatic checkOutput();
        logic [NREG-1:0] mb;
        for (int i = 0; i < NREG; i++) mb[i] = m_busy[i];
        check("ex_valid", 64'(ex_valid_o), 64'(m_valid));
        check("ex_pc",    ex_pc_o,         m_pc);
        check("ex_instr", 64'(ex_instr_o), 64'(m_instr));
        check("ex_rs1",   64'(ex_rs1_o),   64'(m_rs1));
        check("ex_rs2",   64'(ex_rs2_o),   64'(m_rs2));
        check("ex_rd",    64'(ex_rd_o),    64'(m_rd));
        check("ex_long",  64'(ex_long_o),  64'(m_long));
        check("busy",     64'(busy_o),     64'(mb));
        check("outst",    64'(outst_o),    64'(m_outst));
    endtask

    // One cycle: drive at negedge, check ready before the edge, registered state after
    task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit clr, input int clr_rd,
                                 input bit erdy, input bit fl);
        bit u1, u2, wr, lng, clr_ok, hazard, free, fire, exp_ready;
        int r1, r2, rd;
        bit eff[NREG];
        logic [63:0] pc;
        pc = pc_ctr;
        pc_ctr = pc_ctr + 64'd4;
        @(negedge clk);
        in_valid_i = v; instr_i = ins; pc_i = pc; wb_clr_i = clr;
        wb_rdid_i = 5'(clr_rd); ex_ready_i = erdy; flush_i = fl;
        model_decode(ins, u1, u2, wr, lng, r1, r2, rd);
        clr_ok = clr && (clr_rd != 0) && m_busy[clr_rd];
        for (int i = 0; i < NREG; i++) eff[i] = m_busy[i] && !(clr_ok && i == clr_rd);
        hazard = (u1 && eff[r1]) || (u2 && eff[r2]) || (wr && eff[rd]) ||
                 (lng && m_outst == MAX_OUTST && !clr_ok);
        free      = !m_valid || erdy;
        exp_ready = free && !hazard && !fl;
        fire      = v && exp_ready;
        #1;
        last_ready = in_ready_o;
        check("in_ready", 64'(in_ready_o), 64'(exp_ready));
        @(posedge clk);
        if (clr_ok) begin m_busy[clr_rd] = 1'b0; m_outst--; end
        if (fire && lng) begin m_busy[rd] = 1'b1; m_outst++; end
        if (fl) m_valid = 1'b0;
        else if (fire) begin
            m_valid = 1'b1; m_pc = pc; m_instr = ins;
            m_rs1 = r1; m_rs2 = r2; m_rd = rd; m_long = lng;
        end else if (free) m_valid = 1'b0;
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; in_valid_i = 1'b0; wb_clr_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          v;
        logic [31:0] ins;
        bit          clr;
        int          clr_rd;
        bit          exp_ready;
        bit          exp_valid;
        int          exp_rd;
        logic [31:0] exp_busy;
        int          exp_outst;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [63:0] held_pc;
        rst = 1'b1; in_valid_i = 0; instr_i = '0; pc_i = '0; flush_i = 0;
        wb_clr_i = 0; wb_rdid_i = '0; ex_ready_i = 1;

        // Load-use stall resolved by a same-cycle writeback, then x0 immunity
        vecs[0] = '{1, ld(5, 1),      0, 0, 1, 1, 5, 32'h0000_0020, 1};
        vecs[1] = '{1, add(6, 5, 2),  0, 0, 0, 0, 5, 32'h0000_0020, 1};
        vecs[2] = '{1, add(6, 5, 2),  0, 0, 0, 0, 5, 32'h0000_0020, 1};
        vecs[3] = '{1, add(6, 5, 2),  1, 5, 1, 1, 6, 32'h0000_0000, 0};
        vecs[4] = '{1, ld(0, 1),      0, 0, 1, 1, 0, 32'h0000_0000, 0};
        vecs[5] = '{1, add(3, 0, 0),  0, 0, 1, 1, 3, 32'h0000_0000, 0};
        vecs[6] = '{0, 32'h0,         0, 0, 1, 0, 3, 32'h0000_0000, 0};

        doReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].v, vecs[i].ins, vecs[i].clr, vecs[i].clr_rd, 1, 0);
            check($sformatf("vec%0d_ready", i), 64'(last_ready), 64'(vecs[i].exp_ready));
            check($sformatf("vec%0d_valid", i), 64'(ex_valid_o), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_rd", i),    64'(ex_rd_o),    64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_busy", i),  64'(busy_o),     64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_outst", i), 64'(outst_o),    64'(vecs[i].exp_outst));
        end

        // WAW: a write to a busy register waits indefinitely without writeback
        applyStimulus(1, ld(7, 0), 0, 0, 1, 0);
        for (int i = 0; i < 22; i++) begin
            applyStimulus(1, addi(7, 0, 1), 0, 0, 1, 0);
            check("waw_stall", 64'(last_ready), 64'd0);
        end
        applyStimulus(1, addi(7, 0, 1), 1, 7, 1, 0);
        check("waw_release", 64'(last_ready), 64'd1);
        check("waw_busy7", 64'(busy_o[7]), 64'd0);

        // Outstanding limit: fifth load waits for a retiring writeback
        for (int r = 1; r <= 4; r++) applyStimulus(1, ld(r, 0), 0, 0, 1, 0);
        check("full_outst", 64'(outst_o), 64'd4);
        applyStimulus(1, ld(8, 0), 0, 0, 1, 0);
        check("full_stall", 64'(last_ready), 64'd0);
        applyStimulus(1, ld(8, 0), 1, 1, 1, 0);
        check("full_swap_fire", 64'(last_ready), 64'd1);
        check("full_swap_outst", 64'(outst_o), 64'd4);
        check("full_swap_busy", 64'(busy_o), 64'h0000_011C);
        applyStimulus(0, 32'h0, 1, 2, 1, 0);
        applyStimulus(0, 32'h0, 1, 3, 1, 0);
        applyStimulus(0, 32'h0, 1, 4, 1, 0);
        applyStimulus(0, 32'h0, 1, 8, 1, 0);
        check("drain_outst", 64'(outst_o), 64'd0);

        // Back-pressure holds the EX register; flush drops it but keeps busy bits
        held_pc = pc_ctr;
        applyStimulus(1, addi(10, 0, 1), 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, addi(11, 0, 2), 0, 0, 0, 0);
            check("bp_pc", ex_pc_o, held_pc);
            check("bp_rd", 64'(ex_rd_o), 64'd10);
            check("bp_valid", 64'(ex_valid_o), 64'd1);
        end
        applyStimulus(1, ld(5, 0), 0, 0, 1, 0);
        applyStimulus(1, add(12, 0, 0), 0, 0, 1, 1);
        check("flush_valid", 64'(ex_valid_o), 64'd0);
        check("flush_busy5", 64'(busy_o[5]), 64'd1);
        applyStimulus(0, 32'h0, 1, 5, 1, 0);

        // Same-cycle set and clear of x9: set wins, count unchanged
        applyStimulus(1, ld(9, 0), 0, 0, 1, 0);
        applyStimulus(1, ld(9, 0), 1, 9, 1, 0);
        check("sc_fire", 64'(last_ready), 64'd1);
        check("sc_busy9", 64'(busy_o[9]), 64'd1);
        check("sc_outst", 64'(outst_o), 64'd1);
        applyStimulus(0, 32'h0, 1, 9, 1, 0);

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            int a, b, c, crd, blist[$];
            bit clr;
            a = $urandom_range(0, 7); b = $urandom_range(0, 7); c = $urandom_range(0, 7);
            case ($urandom_range(0, 8))
                0, 1: ins = ld(a, b);
                2:    ins = add(a, b, c);
                3:    ins = addi(a, b, 5);
                4:    ins = sd(a, b);
                5:    ins = beq(a, b);
                6:    ins = jal(a);
                7:    ins = lui(a);
                default: ins = mul(a, b, c);
            endcase
            blist.delete();
            for (int r = 1; r < NREG; r++) if (m_busy[r]) blist.push_back(r);
            clr = 1'b0; crd = 0;
            if (blist.size() > 0 && $urandom_range(0, 99) < 40) begin
                clr = 1'b1; crd = blist[$urandom_range(0, blist.size() - 1)];
            end else if (m_outst < MAX_OUTST && $urandom_range(0, 99) < 10) begin
                clr = 1'b1; crd = $urandom_range(0, 7);
            end
            applyStimulus($urandom_range(0, 99) < 80, ins, clr, crd,
                          $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 8);
        end

        // Reset with tracking in flight discards everything
        applyStimulus(1, ld(3, 0), 1, 0, 1, 0);
        doReset();
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_outst", 64'(outst_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
